bec_serial_tx_n42k32: RTL and testbench
=======================================

// Module: bec_serial_tx_n42k32
// PURPOSE
//  Transmit end of the (42,32) burst-4 error-correcting serial link.
//  - Accepts 32-bit messages over a valid/ready handshake and computes the 10 parity bits.
//  - Serialises codeword c[0:41] = {m[0:31], p[0:9]} onto a LANE_W-bit lane, c[0] first.
//  - A wire burst spanning 4 consecutive bits therefore hits 4 consecutive codeword bits,
//    which is exactly what the receive-side burst decoder corrects.
//  - The far end deserialises the lane and feeds the existing combinational decoder.
// PARAMETERS
//  LANE_W   1   lane width in bits; legal values 1 or 2; BEATS = 42/LANE_W (42 or 21)
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  m_valid    in   1       message valid
//  m_data     in   [0:31]  message; m_data[0] is c[0]
//  m_ready    out  1       holding register empty; transfer = m_valid & m_ready
//  tx_data    out  LANE_W  current beat; tx_data[0] carries the lower codeword index
//  tx_en      out  1       tx_data valid
//  tx_ready   in   1       PHY accepts beat; beat advances = tx_en & tx_ready
//  tx_last    out  1       current beat carries c[41]
//  busy       out  1       shifter or holding register occupied
// BEHAVIOUR
//  - Parity is computed combinationally on m_data at acceptance and stored as a 42-bit codeword.
//    Every p[k] below is the XOR of the m bits listed:
//    - p[i], i = 0..3: all m[j] with j mod 4 == i
//    - p4: 0 1 2 6 8 12 13 14 15 17 18 19 20 26
//    - p5: 0 2 3 4 6 7 9 10 12 13 17 21 22 27
//    - p6: 3 8 9 12 14 16 18 19 23 24 28
//    - p7: 0 1 2 5 6 7 10 11 12 13 14 15 16 17 18 20 21 23 24 25 29
//    - p8: 0 1 4 6 8 9 10 12 13 15 16 21 22 23 25 26 30
//    - p9: 0 1 3 5 8 12 13 14 15 16 19 20 22 24 25 27 31
//  - Storage: hold register (1 codeword + hold_full), 42-bit shifter, beat counter 0..BEATS-1.
//  - FSM states:
//    - IDLE: tx_en = 0. If hold_full: load shifter, clear hold_full, cnt <= 0, go to SEND.
//    - SEND: tx_en = 1. Each advance shifts by LANE_W and increments cnt.
//      - Advance on cnt == BEATS-1 with hold_full: reload the shifter, cnt <= 0, stay in SEND.
//        This gives back-to-back codewords with zero idle beats.
//      - Advance on cnt == BEATS-1 without hold_full: go to IDLE.
//  - m_ready = ~hold_full, registered. An accept and a hold->shifter move in the same cycle
//    are both legal: the hold register takes the new word and hold_full stays 1.
//  - Latency: word accepted at edge E -> first beat on tx_data with tx_en = 1 in the cycle
//    after edge E+1, provided the link was IDLE.
//  - tx_ready low: tx_data, tx_last and cnt hold. m_ready still obeys the hold register.
//  - tx_last = tx_en & (cnt == BEATS-1).
//  - No beat is ever dropped or duplicated. tx_en never drops mid-codeword.
//  - Reset (async assert, sync release) mid-codeword aborts the codeword silently.
//    All state clears: tx_en = 0, tx_data = 0, tx_last = 0, m_ready = 1, busy = 0,
//    FSM = IDLE, cnt = 0, hold_full = 0.
// CONFIGURATION
//  BEC_TX_SOF_EN defined:
//  - Adds output tx_sof (1 bit) = tx_en & (cnt == 0), marking the beat that carries c[0].
//  - tx_sof resets to 0 and holds during tx_ready stalls like tx_data.
//  BEC_TX_SOF_EN undefined: tx_sof port and logic are absent; all other behaviour is identical.
// TESTING
//  1. LANE_W=1, m_data=32'h0, tx_ready=1 -> 42 beats of 0; tx_last on beat 42 only;
//     m_ready drops for exactly 1 cycle.
//  2. LANE_W=1, m_data=32'h8000_0000 -> bits 1, 31x0, then parity 1000110111;
//     and m_data=32'h0000_0001 -> 31x0, 1, then parity 0001000001.
//  3. LANE_W=2, m_data=32'hFFFF_FFFF -> 16 beats of 2'b11, then parity 0000001111
//     over 5 beats; 21 beats total.
//  4. Three words offered back-to-back -> 126 consecutive beats with tx_en=1, no gap;
//     m_ready low only while the hold register is full.
//  5. tx_ready toggled pseudo-randomly -> the captured bitstream is identical to run 2;
//     tx_data and cnt are stable whenever tx_ready=0.
//  6. rst_n pulsed low at beat 20 -> outputs clear immediately in the same cycle;
//     the next accepted word serialises from c[0].
//     With BEC_TX_SOF_EN, tx_sof pulses once per codeword, on the first beat.

Source files
------------

// File: rtl/bec_serial_tx_n42k32_if.sv
// Bundle of the message-side handshake and the serial lane for the (42,32)
// burst-4 transmitter. The master side feeds messages and drives tx_ready;
// the slave side is the transmitter itself.
// Optional macro BEC_TX_SOF_EN adds the tx_sof start-of-codeword marker.
interface bec_serial_tx_n42k32_if #(
    parameter int LANE_W = 1
);
    logic              m_valid;
    logic [0:31]       m_data;
    logic              m_ready;
    logic [LANE_W-1:0] tx_data;
    logic              tx_en;
    logic              tx_ready;
    logic              tx_last;
    logic              busy;

`ifdef BEC_TX_SOF_EN
    logic              tx_sof;

    modport master (
        output m_valid, m_data, tx_ready,
        input  m_ready, tx_data, tx_en, tx_last, busy, tx_sof
    );

    modport slave (
        input  m_valid, m_data, tx_ready,
        output m_ready, tx_data, tx_en, tx_last, busy, tx_sof
    );
`else
    modport master (
        output m_valid, m_data, tx_ready,
        input  m_ready, tx_data, tx_en, tx_last, busy
    );

    modport slave (
        input  m_valid, m_data, tx_ready,
        output m_ready, tx_data, tx_en, tx_last, busy
    );
`endif
endinterface

// File: rtl/bec_serial_tx_n42k32.sv
// Transmit end of the (42,32) burst-4 error-correcting serial link.
// A 32-bit message is encoded into c[0:41] = {m[0:31], p[0:9]} when it is
// accepted, parked in a one-deep hold register, then shifted out LANE_W bits
// per beat, c[0] first. A queued codeword is reloaded on the last beat of the
// current one so consecutive codewords leave with no idle beat between them.
// LANE_W must be 1 or 2.
// Optional macro BEC_TX_SOF_EN adds tx_sof, high on the beat carrying c[0].
//
// state | meaning
// IDLE  | lane quiet, waiting for the hold register to fill
// SEND  | shifting a codeword out, one beat per tx_en & tx_ready
module bec_serial_tx_n42k32 #(
    parameter int LANE_W = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bec_serial_tx_n42k32_if.slave  bus
);

    localparam int             BEATS    = 42 / LANE_W;
    localparam logic [5:0]     CNT_LAST = 6'(BEATS - 1);
    localparam logic [5:0]     CNT_PREV = 6'(BEATS - 2);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t      state;
    logic [41:0] hold_cw;
    logic        hold_full;
    logic [41:0] shifter;
    logic [5:0]  cnt;
    logic        tx_en_r;
    logic        tx_last_r;

    logic        accept;
    logic        last_beat;
    logic        move;
    logic [41:0] new_cw;

    // Bit i of the returned vector is codeword bit c[i].
    function automatic logic [41:0] encode(input logic [0:31] m);
        logic [0:9]  p;
        logic [41:0] cw;
        p = '0;
        for (int j = 0; j < 32; j++) begin
            p[j % 4] = p[j % 4] ^ m[j];
        end
        p[4] = m[0] ^ m[1] ^ m[2] ^ m[6] ^ m[8] ^ m[12] ^ m[13] ^ m[14] ^ m[15]
             ^ m[17] ^ m[18] ^ m[19] ^ m[20] ^ m[26];
        p[5] = m[0] ^ m[2] ^ m[3] ^ m[4] ^ m[6] ^ m[7] ^ m[9] ^ m[10] ^ m[12]
             ^ m[13] ^ m[17] ^ m[21] ^ m[22] ^ m[27];
        p[6] = m[3] ^ m[8] ^ m[9] ^ m[12] ^ m[14] ^ m[16] ^ m[18] ^ m[19]
             ^ m[23] ^ m[24] ^ m[28];
        p[7] = m[0] ^ m[1] ^ m[2] ^ m[5] ^ m[6] ^ m[7] ^ m[10] ^ m[11] ^ m[12]
             ^ m[13] ^ m[14] ^ m[15] ^ m[16] ^ m[17] ^ m[18] ^ m[20] ^ m[21]
             ^ m[23] ^ m[24] ^ m[25] ^ m[29];
        p[8] = m[0] ^ m[1] ^ m[4] ^ m[6] ^ m[8] ^ m[9] ^ m[10] ^ m[12] ^ m[13]
             ^ m[15] ^ m[16] ^ m[21] ^ m[22] ^ m[23] ^ m[25] ^ m[26] ^ m[30];
        p[9] = m[0] ^ m[1] ^ m[3] ^ m[5] ^ m[8] ^ m[12] ^ m[13] ^ m[14] ^ m[15]
             ^ m[16] ^ m[19] ^ m[20] ^ m[22] ^ m[24] ^ m[25] ^ m[27] ^ m[31];
        for (int i = 0; i < 32; i++) begin
            cw[i] = m[i];
        end
        for (int k = 0; k < 10; k++) begin
            cw[32 + k] = p[k];
        end
        return cw;
    endfunction

    assign new_cw    = encode(bus.m_data);
    assign accept    = bus.m_valid & ~hold_full;
    assign last_beat = (state == SEND) & bus.tx_ready & (cnt == CNT_LAST);
    // The hold register empties whenever the shifter takes its codeword.
    assign move      = hold_full & ((state == IDLE) | last_beat);

    assign bus.m_ready = ~hold_full;
    assign bus.busy    = tx_en_r | hold_full;
    assign bus.tx_en   = tx_en_r;
    assign bus.tx_last = tx_last_r;
    assign bus.tx_data = shifter[LANE_W-1:0];

    // Hold register: a new word wins over the move so hold_full stays set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cw   <= '0;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_cw   <= new_cw;
            hold_full <= 1'b1;
        end else if (move) begin
            hold_full <= 1'b0;
        end
    end

    // Serialiser FSM with registered tx_en / tx_last; everything holds on a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shifter   <= '0;
            cnt       <= '0;
            tx_en_r   <= 1'b0;
            tx_last_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hold_full) begin
                        shifter   <= hold_cw;
                        cnt       <= '0;
                        tx_en_r   <= 1'b1;
                        tx_last_r <= 1'b0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (bus.tx_ready) begin
                        if (cnt == CNT_LAST) begin
                            cnt       <= '0;
                            tx_last_r <= 1'b0;
                            if (hold_full) begin
                                shifter <= hold_cw;
                            end else begin
                                shifter <= '0;
                                tx_en_r <= 1'b0;
                                state   <= IDLE;
                            end
                        end else begin
                            shifter   <= shifter >> LANE_W;
                            cnt       <= cnt + 6'd1;
                            tx_last_r <= (cnt == CNT_PREV);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef BEC_TX_SOF_EN
    logic tx_sof_r;

    // Start-of-codeword flag: set by every load or reload, cleared by any other advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sof_r <= 1'b0;
        end else if (move) begin
            tx_sof_r <= 1'b1;
        end else if ((state == SEND) && bus.tx_ready) begin
            tx_sof_r <= 1'b0;
        end
    end

    assign bus.tx_sof = tx_sof_r;
`endif

endmodule

// File: tb/tb_bec_serial_tx_n42k32.sv
// Bench for bec_serial_tx_n42k32: one instance per lane width (1 and 2),
// sharing clock and reset. Message queues feed each lane; the serial output
// of each lane is collected as a bitstream and compared with codewords built
// from the parity equations.
module tb_bec_serial_tx_n42k32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bec_serial_tx_n42k32_if #(.LANE_W(1)) bus1 ();
    bec_serial_tx_n42k32_if #(.LANE_W(2)) bus2 ();

    bec_serial_tx_n42k32 #(.LANE_W(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    bec_serial_tx_n42k32 #(.LANE_W(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    logic [1:0] rdy;
    logic       rand_mode = 1'b0;
    assign bus1.tx_ready = rdy[0];
    assign bus2.tx_ready = rdy[1];

    logic [1:0] en_w, last_w, mrdy_w;
    logic [1:0] dat_w [2];
    assign en_w     = {bus2.tx_en, bus1.tx_en};
    assign last_w   = {bus2.tx_last, bus1.tx_last};
    assign mrdy_w   = {bus2.m_ready, bus1.m_ready};
    assign dat_w[0] = {1'b0, bus1.tx_data};
    assign dat_w[1] = bus2.tx_data;
`ifdef BEC_TX_SOF_EN
    logic [1:0] sof_w;
    assign sof_w = {bus2.tx_sof, bus1.tx_sof};
`endif

    int checks = 0;
    int failures = 0;

    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    int ptr0 = 0;
    int ptr1 = 0;
    bit exp0 [$];
    bit exp1 [$];

    // Monitor-owned observations, cleared whenever clr_gen changes.
    int clr_gen = 0;
    int seen_gen = 0;
    bit cap0 [$];
    bit cap1 [$];
    int beat_idx [2];
    int run_len [2];
    int max_run [2];
    int mrdy_low [2];
    int last_cnt [2];
    int sof_cnt [2];
    int mon_bad [2];
    bit stall_prev [2];
    logic [1:0] dat_prev [2];
    logic last_prev [2];
    bit adv;

    typedef struct packed {
        logic [31:0] data;
        logic [0:9]  par;
    } vec_t;
    vec_t tv [4];

    function automatic int beats_of(input int l);
        return (l == 0) ? 42 : 21;
    endfunction

    function automatic bit in_list(input int k, input int j);
        case (k)
            4: return j inside {0, 1, 2, 6, 8, 12, 13, 14, 15, 17, 18, 19, 20, 26};
            5: return j inside {0, 2, 3, 4, 6, 7, 9, 10, 12, 13, 17, 21, 22, 27};
            6: return j inside {3, 8, 9, 12, 14, 16, 18, 19, 23, 24, 28};
            7: return j inside {0, 1, 2, 5, 6, 7, 10, 11, 12, 13, 14, 15, 16, 17, 18, 20, 21, 23, 24, 25, 29};
            8: return j inside {0, 1, 4, 6, 8, 9, 10, 12, 13, 15, 16, 21, 22, 23, 25, 26, 30};
            9: return j inside {0, 1, 3, 5, 8, 12, 13, 14, 15, 16, 19, 20, 22, 24, 25, 27, 31};
            default: return (j % 4) == k;
        endcase
    endfunction

    // m[j] is data[31-j]; the result holds c[i] in bit i.
    function automatic logic [41:0] model_cw(input logic [31:0] data);
        logic [41:0] c;
        bit pk;
        for (int j = 0; j < 32; j++) c[j] = data[31 - j];
        for (int k = 0; k < 10; k++) begin
            pk = 1'b0;
            for (int j = 0; j < 32; j++) if (in_list(k, j)) pk = pk ^ data[31 - j];
            c[32 + k] = pk;
        end
        return c;
    endfunction

    task automatic push_exp(input logic [41:0] c);
        for (int i = 0; i < 42; i++) begin
            exp0.push_back(c[i]);
            exp1.push_back(c[i]);
        end
    endtask

    task automatic send_both(input logic [31:0] w);
        q0.push_back(w);
        q1.push_back(w);
    endtask

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, want);
        end
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_lane1"}, int'({bus1.tx_en, bus1.tx_last, bus1.m_ready, bus1.busy, bus1.tx_data}), 4);
        chk({name, "_lane2"}, int'({bus2.tx_en, bus2.tx_last, bus2.m_ready, bus2.busy, bus2.tx_data}), 8);
`ifdef BEC_TX_SOF_EN
        chk({name, "_sof"}, int'(sof_w), 0);
`endif
    endtask

    task automatic start_phase();
        clr_gen++;
        exp0.delete();
        exp1.delete();
        @(negedge clk);
        #1;
    endtask

    task automatic run_phase(input string name, input int budget);
        int n;
        bit pend;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
            pend = (ptr0 < q0.size()) || (ptr1 < q1.size()) || bus1.m_valid || bus2.m_valid
                   || bus1.busy || bus2.busy;
        end while (pend && n < budget);
        chk({name, "_done"}, int'(pend), 0);
    endtask

    task automatic cmp_streams(input string name);
        int bad;
        chk({name, "_len_l1"}, cap0.size(), exp0.size());
        bad = -1;
        for (int i = 0; i < cap0.size() && i < exp0.size(); i++)
            if (bad < 0 && cap0[i] != exp0[i]) bad = i;
        chk({name, "_first_bad_bit_l1"}, bad, -1);
        chk({name, "_len_l2"}, cap1.size(), exp1.size());
        bad = -1;
        for (int i = 0; i < cap1.size() && i < exp1.size(); i++)
            if (bad < 0 && cap1[i] != exp1[i]) bad = i;
        chk({name, "_first_bad_bit_l2"}, bad, -1);
        chk({name, "_beat_rules"}, mon_bad[0] + mon_bad[1], 0);
    endtask

    // Lane 1 message source.
    initial begin
        bit acc;
        bus1.m_valid = 1'b0;
        bus1.m_data  = '0;
        forever begin
            @(negedge clk);
            acc = bus1.m_valid && bus1.m_ready && rst_n;
            @(posedge clk);
            #1;
            if (acc) ptr0++;
            if (ptr0 < q0.size()) begin
                bus1.m_valid = 1'b1;
                bus1.m_data  = q0[ptr0];
            end else begin
                bus1.m_valid = 1'b0;
            end
        end
    end

    // Lane 2 message source.
    initial begin
        bit acc;
        bus2.m_valid = 1'b0;
        bus2.m_data  = '0;
        forever begin
            @(negedge clk);
            acc = bus2.m_valid && bus2.m_ready && rst_n;
            @(posedge clk);
            #1;
            if (acc) ptr1++;
            if (ptr1 < q1.size()) begin
                bus2.m_valid = 1'b1;
                bus2.m_data  = q1[ptr1];
            end else begin
                bus2.m_valid = 1'b0;
            end
        end
    end

    // PHY back-pressure.
    initial begin
        rdy = 2'b11;
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) rdy = {1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0)};
            else           rdy = 2'b11;
        end
    end

    // Lane monitor: samples at the falling edge, what it sees is what the next rising edge uses.
    initial begin
        for (int l = 0; l < 2; l++) begin
            dat_prev[l]   = '0;
            last_prev[l]  = 1'b0;
            stall_prev[l] = 1'b0;
        end
        forever begin
            @(negedge clk);
            if (seen_gen != clr_gen) begin
                seen_gen = clr_gen;
                cap0.delete();
                cap1.delete();
                for (int l = 0; l < 2; l++) begin
                    beat_idx[l] = 0; run_len[l] = 0; max_run[l] = 0; mrdy_low[l] = 0;
                    last_cnt[l] = 0; sof_cnt[l] = 0; mon_bad[l] = 0;
                end
            end
            if (!rst_n) begin
                for (int l = 0; l < 2; l++) begin
                    stall_prev[l] = 1'b0;
                    run_len[l]    = 0;
                    beat_idx[l]   = 0;
                end
            end else begin
                for (int l = 0; l < 2; l++) begin
                    adv = en_w[l] && rdy[l];
                    if (stall_prev[l] && !(en_w[l] && dat_w[l] == dat_prev[l] && last_w[l] == last_prev[l])) begin
                        mon_bad[l]++;
                        $display("FAIL stall_hold lane%0d got en=%0b data=%0h last=%0b required en=1 data=%0h last=%0b",
                                 l + 1, en_w[l], dat_w[l], last_w[l], dat_prev[l], last_prev[l]);
                    end
                    if (!en_w[l] && beat_idx[l] != 0) begin
                        mon_bad[l]++;
                        $display("FAIL en_drop lane%0d tx_en=0 at beat %0d, required 1", l + 1, beat_idx[l]);
                    end
                    if (en_w[l]) begin
                        if (last_w[l] != (beat_idx[l] == beats_of(l) - 1)) begin
                            mon_bad[l]++;
                            $display("FAIL tx_last lane%0d beat %0d got %0b", l + 1, beat_idx[l], last_w[l]);
                        end
`ifdef BEC_TX_SOF_EN
                        if (sof_w[l] != (beat_idx[l] == 0)) begin
                            mon_bad[l]++;
                            $display("FAIL tx_sof lane%0d beat %0d got %0b", l + 1, beat_idx[l], sof_w[l]);
                        end
                        if (adv && sof_w[l]) sof_cnt[l]++;
`endif
                        run_len[l]++;
                        if (run_len[l] > max_run[l]) max_run[l] = run_len[l];
                    end else begin
                        run_len[l] = 0;
                    end
                    if (!mrdy_w[l]) mrdy_low[l]++;
                    if (adv) begin
                        if (last_w[l]) last_cnt[l]++;
                        if (l == 0) begin
                            cap0.push_back(dat_w[0][0]);
                        end else begin
                            cap1.push_back(dat_w[1][0]);
                            cap1.push_back(dat_w[1][1]);
                        end
                        beat_idx[l] = (beat_idx[l] + 1) % beats_of(l);
                    end
                    stall_prev[l] = en_w[l] && !rdy[l];
                    dat_prev[l]   = dat_w[l];
                    last_prev[l]  = last_w[l];
                end
            end
        end
    end

    initial begin
        logic [41:0] c;
        logic [31:0] w;
        string nm;
        int n;

        tv[0] = '{data: 32'h0000_0000, par: 10'b0000000000};
        tv[1] = '{data: 32'h8000_0000, par: 10'b1000110111};
        tv[2] = '{data: 32'h0000_0001, par: 10'b0001000001};
        tv[3] = '{data: 32'hFFFF_FFFF, par: 10'b0000001111};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("reset_hold");
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk_reset("after_release");

        // Fixed vectors: one codeword each on both lanes, PHY always ready.
        for (int v = 0; v < 4; v++) begin
            nm = $sformatf("vec%0d", v);
            start_phase();
            for (int j = 0; j < 32; j++) c[j] = tv[v].data[31 - j];
            for (int k = 0; k < 10; k++) c[32 + k] = tv[v].par[k];
            push_exp(c);
            send_both(tv[v].data);
            run_phase(nm, 400);
            cmp_streams(nm);
            chk({nm, "_mready_low_l1"}, mrdy_low[0], 1);
            chk({nm, "_mready_low_l2"}, mrdy_low[1], 1);
            chk({nm, "_last_pulses_l1"}, last_cnt[0], 1);
            chk({nm, "_last_pulses_l2"}, last_cnt[1], 1);
`ifdef BEC_TX_SOF_EN
            chk({nm, "_sof_pulses"}, sof_cnt[0] + sof_cnt[1], 2);
`endif
        end

        // Three words back to back: a single unbroken run of beats per lane.
        start_phase();
        for (int i = 0; i < 3; i++) begin
            w = $urandom;
            push_exp(model_cw(w));
            send_both(w);
        end
        run_phase("b2b", 600);
        cmp_streams("b2b");
        chk("b2b_run_l1", max_run[0], 126);
        chk("b2b_run_l2", max_run[1], 63);
        chk("b2b_mready_low_l1", mrdy_low[0], 1 + 2 * 41);
        chk("b2b_mready_low_l2", mrdy_low[1], 1 + 2 * 20);
        chk("b2b_last_pulses", last_cnt[0] + last_cnt[1], 6);

        // Random back-pressure over the fixed patterns plus random words.
        rand_mode = 1'b1;
        start_phase();
        push_exp(model_cw(32'h8000_0000));
        send_both(32'h8000_0000);
        push_exp(model_cw(32'h0000_0001));
        send_both(32'h0000_0001);
        for (int i = 0; i < 6; i++) begin
            w = $urandom;
            push_exp(model_cw(w));
            send_both(w);
        end
        run_phase("stall", 4000);
        cmp_streams("stall");
        chk("stall_last_pulses", last_cnt[0] + last_cnt[1], 16);
        rand_mode = 1'b0;
        @(negedge clk);

        // Reset in the middle of a codeword, then a fresh word from c[0].
        start_phase();
        send_both($urandom);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (beat_idx[0] < 20 && n < 200);
        chk("rst_mid_reach_beat20", int'(beat_idx[0] >= 20), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("rst_mid");
        repeat (2) @(negedge clk);
        chk_reset("rst_mid_held");
        rst_n = 1'b1;
        start_phase();
        w = $urandom;
        push_exp(model_cw(w));
        send_both(w);
        run_phase("after_rst", 400);
        cmp_streams("after_rst");
        chk("after_rst_last_pulses", last_cnt[0] + last_cnt[1], 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
